// File: rtl/frame_reader_pkg.sv
// Shared definitions for the frame reader.
// Holds the channel-width helper and its default value, the reader FSM
// state type, and the width of the dropped-pulse counter.
package frame_reader_pkg;

    // Width of the saturating dropped-pulse counter.
    localparam int OVR_CNT_W = 8;

    // Reader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Channel index width for a given microphone count.
    // This is $clog2 of the larger of n_mics and 2, so the width is at least one bit.
    function automatic int ch_width(input int n_mics);
        return (n_mics > 2) ? $clog2(n_mics) : 1;
    endfunction

    // Channel width for the default single-microphone configuration.
    localparam int CH_W = ch_width(1);

endpackage

// File: rtl/frame_reader_if.sv
// Sample stream interface between the frame reader and its sink.
// Signals:
//   data  : streamed sample
//   valid : sample present
//   ready : sink accepts; a beat transfers when valid and ready are both 1
//   last  : final sample of a frame
//   ch    : channel of the current frame
// Modports: master (frame reader side), slave (sink side).
interface frame_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_W       = frame_reader_pkg::CH_W
) ();

    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [CH_W-1:0]       ch;

    modport master (output data, output valid, output last, output ch, input ready);
    modport slave  (input data, input valid, input last, input ch, output ready);

endinterface

// File: rtl/frame_reader_sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push          : write push_data this cycle (ignored when full)
//   push_data     : entry to write
//   pop           : consume the head entry (ignored when empty)
//   head          : oldest entry, valid while not_empty is 1
//   count         : number of stored entries
//   not_empty     : at least one entry stored
module sample_fifo
    import frame_reader_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             not_empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && (count_r != CNT_W'(DEPTH));
    assign pop_ok_s  = pop && (count_r != CNT_W'(0));
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign not_empty = (count_r != CNT_W'(0));

    // Storage, pointers and occupancy. Storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

endmodule

// File: rtl/frame_reader.sv
// frame_reader: streams each completed sampler buffer out as one frame.
// When the sampler pulses buf_ready_pulse_i, the reader latches the channel
// and reads addresses 0..SAMPLES_PER_BUF-1 from the inactive RAM half. It
// pushes the returned samples through a small FIFO onto the stream
// interface and tags the final sample with last.
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   buf_ready_pulse_i   : one-cycle "buffer complete" pulse
//   buf_ready_ch_i      : channel of the completed buffer
//   rd_en_o/rd_addr_o/rd_ch_o : RAM read request
//   rd_data_i/rd_data_valid_i : RAM read return, one cycle after rd_en_o
//   m                   : sample stream (master side)
//   busy_o              : FSM not idle
//   overrun_o           : one-cycle pulse when a ready pulse is dropped
//   overrun_cnt_o       : saturating count of dropped pulses
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int N_MICS          = 1,
    parameter int DATA_WIDTH      = 16,
    parameter int SAMPLES_PER_BUF = 256,
    parameter int ADDR_WIDTH      = $clog2(SAMPLES_PER_BUF),
    parameter int FIFO_DEPTH      = 4,
    localparam int CH_WIDTH       = ch_width(N_MICS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  buf_ready_pulse_i,
    input  logic [CH_WIDTH-1:0]   buf_ready_ch_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [CH_WIDTH-1:0]   rd_ch_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rd_data_valid_i,
    frame_reader_if.master        m,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic [OVR_CNT_W-1:0]  overrun_cnt_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLES_PER_BUF - 1);

    rd_state_e               state_r;
    logic [CH_WIDTH-1:0]     ch_r;
    logic                    rd_en_r;
    logic [ADDR_WIDTH-1:0]   rd_addr_r;
    logic [ADDR_WIDTH-1:0]   next_addr_r;
    logic                    busy_r;
    logic                    overrun_r;
    logic [OVR_CNT_W-1:0]    ovr_cnt_r;
    logic [CNT_W-1:0]        inflight_r;
    logic [ADDR_WIDTH-1:0]   wr_idx_r;

    logic [CNT_W-1:0]        fifo_count_s;
    logic                    fifo_valid_s;
    logic [DATA_WIDTH:0]     fifo_head_s;
    logic [DATA_WIDTH:0]     fifo_push_data_s;
    logic [CNT_W:0]          occupancy_s;
    logic                    issue_s;
    logic                    ret_s;
    logic                    pop_s;
    logic                    last_xfer_s;

    // Credit: the stored samples plus the outstanding reads must leave room
    // for the read being issued. Pops in the same cycle are ignored here.
    // This is conservative, but it still sustains one read per cycle.
    assign occupancy_s = {1'b0, fifo_count_s} + {1'b0, inflight_r};
    assign issue_s     = (state_r == ST_READ) && (occupancy_s < (CNT_W + 1)'(FIFO_DEPTH));
    // A return with nothing outstanding is stray (e.g. a read cut off by reset) and is dropped.
    assign ret_s       = rd_data_valid_i && (inflight_r != CNT_W'(0));
    assign pop_s       = fifo_valid_s && m.ready;
    assign last_xfer_s = pop_s && fifo_head_s[DATA_WIDTH];

    assign fifo_push_data_s = {(wr_idx_r == LAST_ADDR), rd_data_i};

    sample_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (ret_s),
        .push_data (fifo_push_data_s),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .not_empty (fifo_valid_s)
    );

    assign m.valid = fifo_valid_s;
    assign m.data  = fifo_head_s[DATA_WIDTH-1:0];
    assign m.last  = fifo_valid_s & fifo_head_s[DATA_WIDTH];
    assign m.ch    = ch_r;

    assign rd_en_o       = rd_en_r;
    assign rd_addr_o     = rd_addr_r;
    assign rd_ch_o       = ch_r;
    assign busy_o        = busy_r;
    assign overrun_o     = overrun_r;
    assign overrun_cnt_o = ovr_cnt_r;

    // Outstanding-read count and the frame index of the next returned sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_r <= '0;
            wr_idx_r   <= '0;
        end else begin
            inflight_r <= inflight_r + CNT_W'(issue_s) - CNT_W'(ret_s);
            if (ret_s) begin
                wr_idx_r <= (wr_idx_r == LAST_ADDR) ? ADDR_WIDTH'(0) : wr_idx_r + ADDR_WIDTH'(1);
            end
        end
    end

    // Reader FSM, with registered read request, status and overrun outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            ch_r        <= '0;
            rd_en_r     <= 1'b0;
            rd_addr_r   <= '0;
            next_addr_r <= '0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
            ovr_cnt_r   <= '0;
        end else begin
            rd_en_r   <= 1'b0;
            overrun_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (buf_ready_pulse_i) begin
                        ch_r        <= buf_ready_ch_i;
                        rd_addr_r   <= '0;
                        next_addr_r <= '0;
                        state_r     <= ST_READ;
                        busy_r      <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (issue_s) begin
                        rd_en_r     <= 1'b1;
                        rd_addr_r   <= next_addr_r;
                        next_addr_r <= next_addr_r + ADDR_WIDTH'(1);
                        if (next_addr_r == LAST_ADDR) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                    if (buf_ready_pulse_i) begin
                        overrun_r <= 1'b1;
                        if (ovr_cnt_r != {OVR_CNT_W{1'b1}}) begin
                            ovr_cnt_r <= ovr_cnt_r + OVR_CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_xfer_s) begin
                        // The pipeline is empty once the last beat leaves.
                        // A coincident pulse can therefore start the next frame at once.
                        if (buf_ready_pulse_i) begin
                            ch_r        <= buf_ready_ch_i;
                            rd_addr_r   <= '0;
                            next_addr_r <= '0;
                            state_r     <= ST_READ;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else if (buf_ready_pulse_i) begin
                        overrun_r <= 1'b1;
                        if (ovr_cnt_r != {OVR_CNT_W{1'b1}}) begin
                            ovr_cnt_r <= ovr_cnt_r + OVR_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader.
// The model holds the samples each accepted frame must produce, in order,
// as a queue. The checks compare the stream, the read requests and the
// status outputs against that queue and against simple counts.
module tb_frame_reader;
    import frame_reader_pkg::*;

    localparam int DW    = 16;
    localparam int S     = 256;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int CHW   = ch_width(1);

    typedef struct packed {
        logic [DW-1:0]  d;
        logic           l;
        logic [CHW-1:0] c;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           pulse = 1'b0;
    logic [CHW-1:0] pch = '0;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [CHW-1:0] rd_ch;
    logic [DW-1:0]  rd_data = '0;
    logic           rd_valid = 1'b0;
    logic           busy;
    logic           ovr;
    logic [7:0]     ovr_cnt;
    logic           rdy = 1'b0;
    bit             rdy_rand = 1'b0;
    bit             inject = 1'b0;
    logic [DW-1:0]  ram_base = 16'h0000;

    int n_checks = 0;
    int n_pass   = 0;

    beat_t exp_q[$];
    bit    frame_active = 1'b0;
    logic [CHW-1:0] cur_ch = '0;
    int    reads_issued = 0;
    int    beats_done   = 0;
    int    beat_total   = 0;
    int    last_total   = 0;
    int    ovr_seen     = 0;
    int    exp_ovr      = 0;
    bit    hold_pend    = 1'b0;
    beat_t hold_b;

    frame_reader_if #(.DATA_WIDTH(DW), .CH_W(CHW)) m_if ();
    assign m_if.ready = rdy;

    frame_reader #(
        .N_MICS          (1),
        .DATA_WIDTH      (DW),
        .SAMPLES_PER_BUF (S),
        .ADDR_WIDTH      (AW),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .buf_ready_pulse_i (pulse),
        .buf_ready_ch_i    (pch),
        .rd_en_o           (rd_en),
        .rd_addr_o         (rd_addr),
        .rd_ch_o           (rd_ch),
        .rd_data_i         (rd_data),
        .rd_data_valid_i   (rd_valid),
        .m                 (m_if),
        .busy_o            (busy),
        .overrun_o         (ovr),
        .overrun_cnt_o     (ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RAM half: each request returns base+addr on the following cycle.
    always @(posedge clk) begin
        rd_valid <= rd_en | inject;
        rd_data  <= ram_base + DW'(rd_addr);
    end

    // Random ready at 50% when enabled.
    always @(posedge clk) begin
        #1;
        if (rdy_rand) rdy = ($urandom_range(0, 1) == 1);
    end

    // Reference model and stream monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            frame_active = 1'b0;
            reads_issued = 0;
            beats_done   = 0;
            hold_pend    = 1'b0;
            exp_ovr      = 0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", m_if.valid, 1);
                check("hold_beat", {m_if.data, m_if.last, m_if.ch}, hold_b);
            end
            if (rd_en) begin
                reads_issued++;
                check("credit", (reads_issued - beats_done) <= DEPTH, 1);
                check("rd_ch", rd_ch, cur_ch);
            end
            if (ovr) ovr_seen++;
            if (m_if.valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {m_if.data, m_if.last, m_if.ch}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat", {m_if.data, m_if.last, m_if.ch}, e);
                    if (e.l) begin
                        last_total++;
                        frame_active = 1'b0;
                    end
                end
                beats_done++;
                beat_total++;
                hold_pend = 1'b0;
            end else if (m_if.valid) begin
                hold_pend = 1'b1;
                hold_b    = {m_if.data, m_if.last, m_if.ch};
            end else begin
                hold_pend = 1'b0;
            end
            if (pulse) begin
                if (!frame_active) begin
                    for (int i = 0; i < S; i++) begin
                        beat_t b;
                        b.d = ram_base + DW'(i);
                        b.l = (i == S - 1);
                        b.c = pch;
                        exp_q.push_back(b);
                    end
                    frame_active = 1'b1;
                    cur_ch = pch;
                end else if (exp_ovr < 255) begin
                    exp_ovr++;
                end
            end
        end
    end

    task automatic pulse_now(input logic [CHW-1:0] ch);
        pulse = 1'b1;
        pch   = ch;
        @(posedge clk); #1;
        pulse = 1'b0;
    endtask

    task automatic send_pulse(input logic [CHW-1:0] ch);
        @(posedge clk); #1;
        pulse_now(ch);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((busy || exp_q.size() != 0 || m_if.valid) && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, n < 4000, 1);
    endtask

    task automatic wait_beats(input string tag, input int target);
        int n = 0;
        while (beat_total < target && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, n < 4000, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b0, l0, ov0, r0;
        bit any_valid;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", {rd_en, rd_addr, rd_ch, busy, ovr, ovr_cnt}, 0);
        check("rst_stream", {m_if.valid, m_if.data, m_if.last, m_if.ch}, 0);
        rst_ni = 1'b1;

        // Basic frame, ready held high: latency, length, single last
        rdy = 1'b1;
        ram_base = 16'h5000;
        b0 = beat_total; l0 = last_total;
        send_pulse(1'b0);
        lat = 0;
        while (!m_if.valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("first_valid_lat", lat, 3);
        check("first_data", m_if.data, 16'h5000);
        check("busy_in_frame", busy, 1);
        while (busy && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("frame_cycles", lat, S + 3);
        wait_done("done_basic");
        check("beats_basic", beat_total - b0, S);
        check("lasts_basic", last_total - l0, 1);
        check("idle_busy", busy, 0);

        // Random backpressure with a random base on channel 1
        ram_base = 16'($urandom);
        b0 = beat_total; l0 = last_total;
        rdy_rand = 1'b1;
        send_pulse(1'b1);
        wait_done("done_random");
        rdy_rand = 1'b0;
        rdy = 1'b1;
        check("beats_random", beat_total - b0, S);
        check("lasts_random", last_total - l0, 1);

        // Pulse in the middle of a frame is dropped
        ram_base = 16'h5000;
        b0 = beat_total; ov0 = ovr_seen;
        send_pulse(1'b0);
        wait_beats("wait_b100", b0 + 100);
        pulse_now(1'b0);
        wait_done("done_overrun");
        check("ovr_pulses", ovr_seen - ov0, 1);
        check("ovr_cnt_model", ovr_cnt, exp_ovr);
        check("ovr_cnt_one", ovr_cnt, 8'd1);
        check("beats_overrun", beat_total - b0, S);

        // Pulse coincident with the last transfer starts the next frame
        b0 = beat_total; l0 = last_total; ov0 = ovr_seen;
        send_pulse(1'b0);
        lat = 0;
        while (!(m_if.valid && m_if.last && rdy) && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("found_last", lat < 1000, 1);
        ram_base = 16'h7000;
        pulse_now(1'b1);
        wait_done("done_b2b");
        check("beats_b2b", beat_total - b0, 2 * S);
        check("lasts_b2b", last_total - l0, 2);
        check("ovr_b2b", ovr_seen - ov0, 0);
        check("ovr_cnt_b2b", ovr_cnt, 8'd1);

        // Reset mid-frame abandons it
        ram_base = 16'h5000;
        b0 = beat_total; l0 = last_total;
        send_pulse(1'b1);
        wait_beats("wait_b50", b0 + 50);
        rst_ni = 1'b0;
        #1;
        check("midrst_rd", {rd_en, rd_addr, rd_ch, busy, ovr, ovr_cnt}, 0);
        check("midrst_stream", {m_if.valid, m_if.data, m_if.last, m_if.ch}, 0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_last", last_total - l0, 0);
        rst_ni = 1'b1;
        inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        any_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            any_valid |= m_if.valid;
        end
        check("stray_return", any_valid, 0);
        ram_base = 16'h6000;
        b0 = beat_total; l0 = last_total;
        send_pulse(1'b0);
        wait_done("done_after_rst");
        check("beats_after_rst", beat_total - b0, S);
        check("lasts_after_rst", last_total - l0, 1);

        // Long stall after beat 10
        ram_base = 16'h5000;
        b0 = beat_total;
        send_pulse(1'b0);
        wait_beats("wait_b11", b0 + 11);
        rdy = 1'b0;
        check("stall_head", m_if.data, 16'h500B);
        r0 = reads_issued;
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("stall_reads", (reads_issued - r0) <= 4, 1);
        check("stall_valid", m_if.valid, 1);
        check("stall_hold_end", m_if.data, 16'h500B);
        rdy = 1'b1;
        wait_done("done_stall");
        check("beats_stall", beat_total - b0, S);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
